// File: rtl/mul4_fitness_scorer_if.sv
// Signal bundle between the fitness scorer and its tournament controller / candidate.
// The scorer takes the slave side; SW must match the scorer's score width.
interface mul4_fitness_scorer_if #(
    parameter int SW = 7
);
    logic          start;
    logic          busy;
    logic [15:0]   a1;
    logic [15:0]   a0;
    logic [15:0]   b1;
    logic [15:0]   b0;
    logic [15:0]   y3;
    logic [15:0]   y2;
    logic [15:0]   y1;
    logic [15:0]   y0;
    logic          result_valid;
    logic          result_ready;
    logic [SW-1:0] score;
    logic          perfect;
    logic [15:0]   error_slices;

    modport master (
        output start, result_ready, y3, y2, y1, y0,
        input  busy, a1, a0, b1, b0, result_valid, score, perfect, error_slices
    );

    modport slave (
        input  start, result_ready, y3, y2, y1, y0,
        output busy, a1, a0, b1, b0, result_valid, score, perfect, error_slices
    );
endinterface

// File: rtl/mul4_fitness_scorer.sv
// Scores a bit-sliced 2x2 multiplier candidate: drives all 16 operand pairs,
// captures its product bits and counts correct bits over PASSES rotated passes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; stimulus 0, last result held
// DRIVE   | stimulus for current pass held for SETTLE cycles
// CAPTURE | candidate outputs and golden product registered
// ACCUM   | score / error_slices updated; next pass or finish
// DONE    | result_valid high until consumer accepts
module mul4_fitness_scorer #(
    parameter int PASSES = 1,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mul4_fitness_scorer_if.slave   bus
);
    localparam int SW = $clog2(64*PASSES+1);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] FULL_SCORE  = SW'(64*PASSES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE-1);
    localparam logic [3:0]    LAST_PASS   = 4'(PASSES-1);
    localparam logic [15:0]   A1_BASE     = 16'hFF00;
    localparam logic [15:0]   A0_BASE     = 16'hF0F0;
    localparam logic [15:0]   B1_BASE     = 16'hCCCC;
    localparam logic [15:0]   B0_BASE     = 16'hAAAA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_CAPTURE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pass_q, pass_d;
    logic [CW-1:0] settle_q, settle_d;
    logic [15:0]   a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
    logic [63:0]   ycap_q, ycap_d, ecap_q, ecap_d;
    logic [SW-1:0] score_q, score_d;
    logic          perfect_q, perfect_d;
    logic [15:0]   err_q, err_d;

    logic [15:0]   e0, e1, e2, e3, p_a1b0, p_a0b1, p_a1b1, carry;
    logic [63:0]   diff;
    logic [15:0]   slice_mis;

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] sh);
        logic [31:0] t;
        t = {x, x} << sh;
        return t[31:16];
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] x, input logic [3:0] sh);
        logic [31:0] t;
        t = {x, x} >> sh;
        return t[15:0];
    endfunction

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

    // Golden product evaluated bitwise on the words currently being driven
    assign p_a1b0 = a1_q & b0_q;
    assign p_a0b1 = a0_q & b1_q;
    assign p_a1b1 = a1_q & b1_q;
    assign carry  = p_a1b0 & p_a0b1;
    assign e0     = a0_q & b0_q;
    assign e1     = p_a1b0 ^ p_a0b1;
    assign e2     = p_a1b1 ^ carry;
    assign e3     = p_a1b1 & carry;

    assign diff      = ycap_q ^ ecap_q;
    assign slice_mis = diff[63:48] | diff[47:32] | diff[31:16] | diff[15:0];

    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        settle_d  = settle_q;
        a1_d      = a1_q;
        a0_d      = a0_q;
        b1_d      = b1_q;
        b0_d      = b0_q;
        ycap_d    = ycap_q;
        ecap_d    = ecap_q;
        score_d   = score_q;
        perfect_d = perfect_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_DRIVE;
                    pass_d    = '0;
                    settle_d  = SETTLE_LOAD;
                    a1_d      = A1_BASE;
                    a0_d      = A0_BASE;
                    b1_d      = B1_BASE;
                    b0_d      = B0_BASE;
                    score_d   = '0;
                    perfect_d = 1'b0;
                    err_d     = '0;
                end
            end
            S_DRIVE: begin
                if (settle_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_d = settle_q - CW'(1);
                end
            end
            S_CAPTURE: begin
                ycap_d  = {bus.y3, bus.y2, bus.y1, bus.y0};
                ecap_d  = {e3, e2, e1, e0};
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                score_d = score_q + SW'(popcount64(~diff));
                // Mismatch was seen at rotated slice positions; map back to the base slice
                err_d   = err_q | rotr16(slice_mis, pass_q);
                if (pass_q == LAST_PASS) begin
                    state_d   = S_DONE;
                    a1_d      = '0;
                    a0_d      = '0;
                    b1_d      = '0;
                    b0_d      = '0;
                    perfect_d = (score_d == FULL_SCORE);
                end else begin
                    state_d  = S_DRIVE;
                    pass_d   = pass_q + 4'd1;
                    settle_d = SETTLE_LOAD;
                    a1_d     = rotl16(A1_BASE, pass_q + 4'd1);
                    a0_d     = rotl16(A0_BASE, pass_q + 4'd1);
                    b1_d     = rotl16(B1_BASE, pass_q + 4'd1);
                    b0_d     = rotl16(B0_BASE, pass_q + 4'd1);
                end
            end
            S_DONE: begin
                if (bus.result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pass_q    <= '0;
            settle_q  <= '0;
            a1_q      <= '0;
            a0_q      <= '0;
            b1_q      <= '0;
            b0_q      <= '0;
            ycap_q    <= '0;
            ecap_q    <= '0;
            score_q   <= '0;
            perfect_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            settle_q  <= settle_d;
            a1_q      <= a1_d;
            a0_q      <= a0_d;
            b1_q      <= b1_d;
            b0_q      <= b0_d;
            ycap_q    <= ycap_d;
            ecap_q    <= ecap_d;
            score_q   <= score_d;
            perfect_q <= perfect_d;
            err_q     <= err_d;
        end
    end

    assign bus.busy         = (state_q == S_DRIVE) || (state_q == S_CAPTURE) || (state_q == S_ACCUM);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.a1           = a1_q;
    assign bus.a0           = a0_q;
    assign bus.b1           = b1_q;
    assign bus.b0           = b0_q;
    assign bus.score        = score_q;
    assign bus.perfect      = perfect_q;
    assign bus.error_slices = err_q;
endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Bench for mul4_fitness_scorer: a 1-pass and a 4-pass instance driven by
// behavioural candidates, results checked against a per-slice arithmetic model.
module tb_mul4_fitness_scorer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          mode1, mode4;
    logic [63:0] msk;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] a1_hist [0:511];

    mul4_fitness_scorer_if #(.SW(7)) bus1 ();
    mul4_fitness_scorer_if #(.SW(9)) bus4 ();

    mul4_fitness_scorer #(.PASSES(1), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mul4_fitness_scorer #(.PASSES(4), .SETTLE(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Candidate: 0 exact, 1 all-zero, 2 y3 stuck high, 3 exact with bit flips from m
    function automatic logic [63:0] cand(input int mode, input logic [15:0] a1, a0, b1, b0,
                                         input logic [63:0] m);
        logic [63:0] y;
        int a, b, pr;
        y = '0;
        for (int j = 0; j < 16; j++) begin
            a = (a1[j] ? 2 : 0) + (a0[j] ? 1 : 0);
            b = (b1[j] ? 2 : 0) + (b0[j] ? 1 : 0);
            pr = a * b;
            for (int k = 0; k < 4; k++) y[16*k+j] = (((pr >> k) & 1) != 0);
        end
        case (mode)
            1:       y = '0;
            2:       y[63:48] = '1;
            3:       y = y ^ m;
            default: ;
        endcase
        return y;
    endfunction

    assign {bus1.y3, bus1.y2, bus1.y1, bus1.y0} = cand(mode1, bus1.a1, bus1.a0, bus1.b1, bus1.b0, msk);
    assign {bus4.y3, bus4.y2, bus4.y1, bus4.y0} = cand(mode4, bus4.a1, bus4.a0, bus4.b1, bus4.b0, msk);

    // Reference: driven slice j in pass p carries base slice s=(j-p) mod 16, i.e. a=s/4, b=s%4
    function automatic void model(input int mode, input logic [63:0] m, input int passes,
                                  output int sc, output logic [15:0] er);
        int s, g, c, d;
        sc = 0;
        er = '0;
        for (int p = 0; p < passes; p++) begin
            for (int j = 0; j < 16; j++) begin
                s = (j - p + 16) % 16;
                g = (s / 4) * (s % 4);
                case (mode)
                    0:       c = g;
                    1:       c = 0;
                    2:       c = g | 8;
                    default: c = g ^ ((m[48+j] ? 8 : 0) | (m[32+j] ? 4 : 0) |
                                      (m[16+j] ? 2 : 0) | (m[j] ? 1 : 0));
                endcase
                d = g ^ c;
                sc += 4 - $countones(d[3:0]);
                if (d != 0) er[s] = 1'b1;
            end
        end
    endfunction

    function automatic int score_of(input int sel);
        return sel != 0 ? int'(bus4.score) : int'(bus1.score);
    endfunction
    function automatic logic valid_of(input int sel);
        return sel != 0 ? bus4.result_valid : bus1.result_valid;
    endfunction
    function automatic logic busy_of(input int sel);
        return sel != 0 ? bus4.busy : bus1.busy;
    endfunction
    function automatic logic perfect_of(input int sel);
        return sel != 0 ? bus4.perfect : bus1.perfect;
    endfunction
    function automatic logic [15:0] err_of(input int sel);
        return sel != 0 ? bus4.error_slices : bus1.error_slices;
    endfunction
    function automatic logic [15:0] a1_of(input int sel);
        return sel != 0 ? bus4.a1 : bus1.a1;
    endfunction
    function automatic logic [15:0] stim_or(input int sel);
        return sel != 0 ? (bus4.a1 | bus4.a0 | bus4.b1 | bus4.b0)
                        : (bus1.a1 | bus1.a0 | bus1.b1 | bus1.b0);
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) bus4.start = v; else bus1.start = v;
    endtask
    task automatic set_ready(input int sel, input logic v);
        if (sel != 0) bus4.result_ready = v; else bus1.result_ready = v;
    endtask

    task automatic run(input int sel, output int lat);
        int n;
        @(negedge clk); set_start(sel, 1'b1);
        @(posedge clk); #1; set_start(sel, 1'b0);
        a1_hist[0] = a1_of(sel);
        lat = -1;
        n = 0;
        while (lat < 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
            a1_hist[n] = a1_of(sel);
            if (valid_of(sel)) lat = n;
        end
    endtask

    task automatic accept(input int sel);
        @(negedge clk); set_ready(sel, 1'b1);
        @(posedge clk); #1; set_ready(sel, 1'b0);
        n_tests++;
        if (valid_of(sel) !== 1'b0) begin
            n_fail++; $display("FAIL accept_drop[%0d]: result_valid=%0b want 0", sel, valid_of(sel));
        end
    endtask

    task automatic check_result(input string nm, input int sel, input int lat, input int lat_exp,
                                input int sc_exp, input logic [15:0] er_exp);
        n_tests++;
        if (lat != lat_exp) begin
            n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, lat, lat_exp);
        end
        n_tests++;
        if (score_of(sel) != sc_exp) begin
            n_fail++; $display("FAIL %s score: got %0d want %0d", nm, score_of(sel), sc_exp);
        end
        n_tests++;
        if (err_of(sel) !== er_exp) begin
            n_fail++; $display("FAIL %s error_slices: got %h want %h", nm, err_of(sel), er_exp);
        end
        n_tests++;
        if (perfect_of(sel) !== (sc_exp == (sel != 0 ? 256 : 64))) begin
            n_fail++; $display("FAIL %s perfect: got %0b want %0b", nm, perfect_of(sel), sc_exp == (sel != 0 ? 256 : 64));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.start = 1'b0; bus1.result_ready = 1'b0;
        bus4.start = 1'b0; bus4.result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            n_tests++;
            if ({busy_of(s), valid_of(s), perfect_of(s)} !== 3'b000) begin
                n_fail++; $display("FAIL reset_flags[%0d]: got %b want 000", s, {busy_of(s), valid_of(s), perfect_of(s)});
            end
            n_tests++;
            if (score_of(s) != 0 || err_of(s) !== 16'h0) begin
                n_fail++; $display("FAIL reset_score[%0d]: score=%0d err=%h want 0/0000", s, score_of(s), err_of(s));
            end
            n_tests++;
            if (stim_or(s) !== 16'h0) begin
                n_fail++; $display("FAIL reset_stim[%0d]: got %h want 0000", s, stim_or(s));
            end
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_exact_default();
        int lat;
        mode1 = 0;
        run(0, lat);
        check_result("exact_default", 0, lat, 3, 64, 16'h0000);
        n_tests++;
        if (a1_hist[1] !== 16'hFF00) begin
            n_fail++; $display("FAIL exact_default_a1: got %h want ff00", a1_hist[1]);
        end
        accept(0);
    endtask

    task automatic test_zero_candidate();
        int lat;
        mode1 = 1;
        run(0, lat);
        check_result("zero_cand", 0, lat, 3, 50, 16'hEEE0);
        accept(0);
    endtask

    task automatic test_y3_forced();
        int lat;
        mode1 = 2;
        run(0, lat);
        check_result("y3_forced", 0, lat, 3, 49, 16'h7FFF);
        accept(0);
    endtask

    task automatic test_passes4();
        int lat;
        mode4 = 0;
        run(1, lat);
        check_result("passes4", 1, lat, 20, 256, 16'h0000);
        n_tests++;
        if (a1_hist[6] !== 16'hFE01) begin
            n_fail++; $display("FAIL passes4_a1_pass1: got %h want fe01", a1_hist[6]);
        end
        n_tests++;
        if (a1_hist[20] !== 16'h0000) begin
            n_fail++; $display("FAIL passes4_stim_done: got %h want 0000", a1_hist[20]);
        end
        accept(1);
    endtask

    task automatic test_random();
        int lat, sc, sel, passes;
        logic [15:0] er;
        for (int it = 0; it < 10; it++) begin
            sel    = it % 2;
            passes = (sel != 0) ? 4 : 1;
            msk    = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (it == 8) msk = '0;
            if (sel != 0) mode4 = 3; else mode1 = 3;
            model(3, msk, passes, sc, er);
            run(sel, lat);
            check_result("random", sel, lat, (sel != 0) ? 20 : 3, sc, er);
            accept(sel);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        mode1 = 0;
        run(0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bus1.start = (i % 2 == 0); bus1.result_ready = 1'b0;
            @(posedge clk); #1;
            n_tests++;
            if (bus1.result_valid !== 1'b1 || score_of(0) != 64 || bus1.busy !== 1'b0) begin
                n_fail++; $display("FAIL hold_done[%0d]: valid=%0b score=%0d busy=%0b want 1/64/0",
                                   i, bus1.result_valid, score_of(0), bus1.busy);
            end
        end
        @(negedge clk); bus1.start = 1'b1; bus1.result_ready = 1'b1;
        @(posedge clk); #1; bus1.start = 1'b0; bus1.result_ready = 1'b0;
        n_tests++;
        if (bus1.result_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            n_fail++; $display("FAIL start_with_ready: valid=%0b busy=%0b want 0/0", bus1.result_valid, bus1.busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus1.busy !== 1'b0 || score_of(0) != 64 || bus1.perfect !== 1'b1) begin
            n_fail++; $display("FAIL idle_hold: busy=%0b score=%0d perfect=%0b want 0/64/1", bus1.busy, score_of(0), bus1.perfect);
        end
        mode1 = 1;
        run(0, lat);
        check_result("rescan", 0, lat, 3, 50, 16'hEEE0);
        accept(0);
    endtask

    task automatic test_reset_mid();
        int lat;
        mode4 = 0;
        @(negedge clk); bus4.start = 1'b1;
        @(posedge clk); #1; bus4.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        n_tests++;
        if (bus4.busy !== 1'b1 || score_of(1) != 128 || bus4.a1 !== 16'hFC03) begin
            n_fail++; $display("FAIL mid_run_state: busy=%0b score=%0d a1=%h want 1/128/fc03", bus4.busy, score_of(1), bus4.a1);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus4.busy !== 1'b0 || stim_or(1) !== 16'h0 || score_of(1) != 0 || bus4.result_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: busy=%0b stim=%h score=%0d valid=%0b want 0/0000/0/0",
                               bus4.busy, stim_or(1), score_of(1), bus4.result_valid);
        end
        @(negedge clk); rst = 1'b0;
        run(1, lat);
        check_result("after_reset", 1, lat, 20, 256, 16'h0000);
        accept(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mode1 = 0;
        mode4 = 0;
        msk   = '0;
        test_reset();
        test_exact_default();
        test_zero_candidate();
        test_y3_forced();
        test_passes4();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
